mem_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between two requesters: the instruction-fetch port and the execute-stage load/store port.
- Grants one RAM command per cycle.
- Tracks which requester owns the read data returning one cycle later.
- Asserts hold_flag_o to the pipeline controller while fetch is blocked.
- A starvation counter guarantees fetch progress under sustained load/store traffic.

---
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch vs load/store arbiter for one single-port synchronous RAM
module mem_arbiter #(
   parameter int unsigned EX_BURST_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic        if_gnt_o,
   output logic        if_rvalid_o,
   output logic [31:0] if_rdata_o,
   input  logic        ex_rd_req_i,
   input  logic        ex_wr_req_i,
   input  logic [31:0] ex_addr_i,
   input  logic [3:0]  ex_wr_sel_i,
   input  logic [31:0] ex_wr_data_i,
   output logic        ex_gnt_o,
   output logic        ex_rvalid_o,
   output logic [31:0] ex_rdata_o,
   input  logic        flush_i,
   output logic        ram_req_o,
   output logic        ram_we_o,
   output logic [3:0]  ram_sel_o,
   output logic [31:0] ram_addr_o,
   output logic [31:0] ram_wdata_o,
   input  logic [31:0] ram_rdata_i,
   output logic        hold_flag_o
);

   typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_EX} owner_t;

   owner_t     r_owner;
   logic [3:0] r_cnt;

   logic w_ex_req;
   logic w_ex_rd_only;
   logic w_burst_full;

   assign w_ex_req     = ex_rd_req_i | ex_wr_req_i;
   // a simultaneous read+write is treated as a write; the read never gets a response
   assign w_ex_rd_only = ex_rd_req_i & ~ex_wr_req_i;
   assign w_burst_full = (r_cnt == 4'(EX_BURST_MAX));

   assign if_gnt_o    = if_req_i & ~flush_i & (~w_ex_req | w_burst_full);
   assign ex_gnt_o    = w_ex_req & ~if_gnt_o;
   assign hold_flag_o = if_req_i & ~if_gnt_o & ~flush_i;

   assign if_rvalid_o = (r_owner == OWN_IF) & ~flush_i;
   assign ex_rvalid_o = (r_owner == OWN_EX);
   assign if_rdata_o  = if_rvalid_o ? ram_rdata_i : 32'h0;
   assign ex_rdata_o  = ex_rvalid_o ? ram_rdata_i : 32'h0;

   always_comb begin
      ram_req_o   = 1'b0;
      ram_we_o    = 1'b0;
      ram_sel_o   = 4'h0;
      ram_addr_o  = 32'h0;
      ram_wdata_o = 32'h0;
      if (if_gnt_o) begin
         ram_req_o   = 1'b1;
         ram_sel_o   = 4'hF;
         ram_addr_o  = if_addr_i;
      end else if (ex_gnt_o) begin
         ram_req_o   = 1'b1;
         ram_we_o    = ex_wr_req_i;
         ram_sel_o   = ex_wr_req_i ? ex_wr_sel_i : 4'hF;
         ram_addr_o  = ex_addr_i;
         ram_wdata_o = ex_wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= OWN_NONE;
         r_cnt   <= 4'd0;
      end else begin
         if (if_gnt_o)
            r_owner <= OWN_IF;
         else if (ex_gnt_o && w_ex_rd_only)
            r_owner <= OWN_EX;
         else
            r_owner <= OWN_NONE;

         // counts EX grants that overtook a waiting fetch
         if (!if_req_i || if_gnt_o)
            r_cnt <= 4'd0;
         else if (ex_gnt_o && !w_burst_full)
            r_cnt <= r_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o;
   logic        if_rvalid_o;
   logic [31:0] if_rdata_o;
   logic        ex_rd_req_i;
   logic        ex_wr_req_i;
   logic [31:0] ex_addr_i;
   logic [3:0]  ex_wr_sel_i;
   logic [31:0] ex_wr_data_i;
   logic        ex_gnt_o;
   logic        ex_rvalid_o;
   logic [31:0] ex_rdata_o;
   logic        flush_i;
   logic        ram_req_o;
   logic        ram_we_o;
   logic [3:0]  ram_sel_o;
   logic [31:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i;
   logic        hold_flag_o;

   int n_vec = 0;
   int n_err = 0;
   int n_ex_resp;
   int n_if_resp;

   mem_arbiter #(.EX_BURST_MAX(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ex_rd_req_i(ex_rd_req_i), .ex_wr_req_i(ex_wr_req_i), .ex_addr_i(ex_addr_i),
      .ex_wr_sel_i(ex_wr_sel_i), .ex_wr_data_i(ex_wr_data_i), .ex_gnt_o(ex_gnt_o),
      .ex_rvalid_o(ex_rvalid_o), .ex_rdata_o(ex_rdata_o), .flush_i(flush_i),
      .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_sel_o(ram_sel_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
      .hold_flag_o(hold_flag_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      if_req_i     = 1'b0;
      if_addr_i    = 32'h0;
      ex_rd_req_i  = 1'b0;
      ex_wr_req_i  = 1'b0;
      ex_addr_i    = 32'h0;
      ex_wr_sel_i  = 4'h0;
      ex_wr_data_i = 32'h0;
      flush_i      = 1'b0;
      ram_rdata_i  = 32'h0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_if_rvalid", 32'(if_rvalid_o), 32'h0);
      chk("rst_ex_rvalid", 32'(ex_rvalid_o), 32'h0);
      rst_n = 1'b1;
      #1;
      chk("idle_ram_req", 32'(ram_req_o), 32'h0);
      chk("idle_ram_addr", ram_addr_o, 32'h0);
      chk("idle_ram_sel", 32'(ram_sel_o), 32'h0);
      chk("idle_gnts", {30'h0, if_gnt_o, ex_gnt_o}, 32'h0);
      chk("idle_hold", 32'(hold_flag_o), 32'h0);

      // single fetch
      tick(); idle();
      if_req_i = 1'b1; if_addr_i = 32'h100;
      #1;
      chk("f1_if_gnt", 32'(if_gnt_o), 32'h1);
      chk("f1_ram_addr", ram_addr_o, 32'h100);
      chk("f1_ram_we", 32'(ram_we_o), 32'h0);
      chk("f1_ram_sel", 32'(ram_sel_o), 32'hF);
      chk("f1_hold", 32'(hold_flag_o), 32'h0);
      tick(); idle();
      ram_rdata_i = 32'h0000_0013;
      #1;
      chk("f1_if_rvalid", 32'(if_rvalid_o), 32'h1);
      chk("f1_if_rdata", if_rdata_o, 32'h0000_0013);
      chk("f1_ex_rvalid", 32'(ex_rvalid_o), 32'h0);
      chk("f1_hold_resp", 32'(hold_flag_o), 32'h0);

      // EX read beats a waiting fetch
      tick(); idle();
      if_req_i = 1'b1; if_addr_i = 32'h104;
      ex_rd_req_i = 1'b1; ex_addr_i = 32'h200;
      #1;
      chk("c2_ex_gnt", 32'(ex_gnt_o), 32'h1);
      chk("c2_if_gnt", 32'(if_gnt_o), 32'h0);
      chk("c2_hold", 32'(hold_flag_o), 32'h1);
      chk("c2_ram_addr", ram_addr_o, 32'h200);
      chk("c2_ram_we", 32'(ram_we_o), 32'h0);
      tick(); idle();
      ram_rdata_i = 32'hAABB_CCDD;
      #1;
      chk("c2_ex_rvalid", 32'(ex_rvalid_o), 32'h1);
      chk("c2_ex_rdata", ex_rdata_o, 32'hAABB_CCDD);
      chk("c2_if_rvalid", 32'(if_rvalid_o), 32'h0);
      chk("c2_if_rdata", if_rdata_o, 32'h0);

      // sustained stores: four EX grants, then fetch is forced through
      for (int c = 0; c < 6; c++) begin
         tick(); idle();
         if_req_i = 1'b1; if_addr_i = 32'h180;
         ex_wr_req_i = 1'b1; ex_addr_i = 32'h240 + 32'(c * 4);
         ex_wr_sel_i = 4'h3; ex_wr_data_i = 32'hD000_0000 + 32'(c);
         ram_rdata_i = 32'h0000_0EEE;
         #1;
         chk($sformatf("b%0d_if_gnt", c), 32'(if_gnt_o), (c == 4) ? 32'h1 : 32'h0);
         chk($sformatf("b%0d_ex_gnt", c), 32'(ex_gnt_o), (c == 4) ? 32'h0 : 32'h1);
         chk($sformatf("b%0d_ram_we", c), 32'(ram_we_o), (c == 4) ? 32'h0 : 32'h1);
         chk($sformatf("b%0d_ram_sel", c), 32'(ram_sel_o), (c == 4) ? 32'hF : 32'h3);
         chk($sformatf("b%0d_ram_addr", c), ram_addr_o,
             (c == 4) ? 32'h180 : 32'h240 + 32'(c * 4));
         chk($sformatf("b%0d_ram_wdata", c), ram_wdata_o,
             (c == 4) ? 32'h0 : 32'hD000_0000 + 32'(c));
         chk($sformatf("b%0d_hold", c), 32'(hold_flag_o), (c == 4) ? 32'h0 : 32'h1);
         chk($sformatf("b%0d_if_rvalid", c), 32'(if_rvalid_o), (c == 5) ? 32'h1 : 32'h0);
         chk($sformatf("b%0d_if_rdata", c), if_rdata_o, (c == 5) ? 32'h0000_0EEE : 32'h0);
      end
      tick(); idle();
      #1;
      chk("b_tail_rvalid", {30'h0, if_rvalid_o, ex_rvalid_o}, 32'h0);

      // flush kills the fetch response and blocks fetch, EX still served
      tick(); idle();
      if_req_i = 1'b1; if_addr_i = 32'h300;
      #1;
      chk("fl_if_gnt_t", 32'(if_gnt_o), 32'h1);
      tick(); idle();
      if_req_i = 1'b1; if_addr_i = 32'h304;
      ex_rd_req_i = 1'b1; ex_addr_i = 32'h320;
      flush_i = 1'b1; ram_rdata_i = 32'h1234_5678;
      #1;
      chk("fl_if_rvalid", 32'(if_rvalid_o), 32'h0);
      chk("fl_if_rdata", if_rdata_o, 32'h0);
      chk("fl_if_gnt", 32'(if_gnt_o), 32'h0);
      chk("fl_ex_gnt", 32'(ex_gnt_o), 32'h1);
      chk("fl_hold", 32'(hold_flag_o), 32'h0);
      tick(); idle();
      ram_rdata_i = 32'h0000_0055;
      #1;
      chk("fl_ex_rvalid", 32'(ex_rvalid_o), 32'h1);
      chk("fl_ex_rdata", ex_rdata_o, 32'h0000_0055);
      chk("fl_if_rvalid2", 32'(if_rvalid_o), 32'h0);

      // read and write together: write wins, no response
      tick(); idle();
      ex_rd_req_i = 1'b1; ex_wr_req_i = 1'b1;
      ex_addr_i = 32'h380; ex_wr_sel_i = 4'h5; ex_wr_data_i = 32'hCAFE_F00D;
      #1;
      chk("pv_ex_gnt", 32'(ex_gnt_o), 32'h1);
      chk("pv_ram_we", 32'(ram_we_o), 32'h1);
      chk("pv_ram_sel", 32'(ram_sel_o), 32'h5);
      chk("pv_ram_wdata", ram_wdata_o, 32'hCAFE_F00D);
      tick(); idle();
      ram_rdata_i = 32'h9999_9999;
      #1;
      chk("pv_ex_rvalid", 32'(ex_rvalid_o), 32'h0);
      chk("pv_ex_rdata", ex_rdata_o, 32'h0);

      // alternating EX read / IF read
      n_ex_resp = 0;
      n_if_resp = 0;
      for (int k = 0; k < 9; k++) begin
         tick(); idle();
         if (k < 8) begin
            if (k % 2 == 0) begin
               ex_rd_req_i = 1'b1; ex_addr_i = 32'h500 + 32'(k * 4);
            end else begin
               if_req_i = 1'b1; if_addr_i = 32'h600 + 32'(k * 4);
            end
         end
         ram_rdata_i = 32'h1000 + 32'(k);
         #1;
         n_ex_resp += int'(ex_rvalid_o);
         n_if_resp += int'(if_rvalid_o);
         if (k < 8) begin
            chk($sformatf("a%0d_ex_gnt", k), 32'(ex_gnt_o), (k % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("a%0d_if_gnt", k), 32'(if_gnt_o), (k % 2 == 1) ? 32'h1 : 32'h0);
         end
         if (k == 0) begin
            chk("a0_rvalid", {30'h0, if_rvalid_o, ex_rvalid_o}, 32'h0);
         end else begin
            chk($sformatf("a%0d_ex_rvalid", k), 32'(ex_rvalid_o),
                ((k - 1) % 2 == 0) ? 32'h1 : 32'h0);
            chk($sformatf("a%0d_if_rvalid", k), 32'(if_rvalid_o),
                ((k - 1) % 2 == 1) ? 32'h1 : 32'h0);
            chk($sformatf("a%0d_ex_rdata", k), ex_rdata_o,
                ((k - 1) % 2 == 0) ? 32'h1000 + 32'(k) : 32'h0);
            chk($sformatf("a%0d_if_rdata", k), if_rdata_o,
                ((k - 1) % 2 == 1) ? 32'h1000 + 32'(k) : 32'h0);
         end
      end
      chk("a_ex_resp_count", 32'(n_ex_resp), 32'd4);
      chk("a_if_resp_count", 32'(n_if_resp), 32'd4);

      // saturate the burst counter, then reset right after an EX read grant
      for (int c = 0; c < 4; c++) begin
         tick(); idle();
         if_req_i = 1'b1; if_addr_i = 32'h700;
         ex_rd_req_i = 1'b1; ex_addr_i = 32'h400;
         #1;
         chk($sformatf("r%0d_ex_gnt", c), 32'(ex_gnt_o), 32'h1);
      end
      tick(); idle();
      ram_rdata_i = 32'h0000_0077;
      #1;
      chk("r_ex_rvalid_pre", 32'(ex_rvalid_o), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("r_ex_rvalid_async", 32'(ex_rvalid_o), 32'h0);
      chk("r_ex_rdata_async", ex_rdata_o, 32'h0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("r_ex_rvalid_rel", 32'(ex_rvalid_o), 32'h0);
      tick(); idle();
      if_req_i = 1'b1; if_addr_i = 32'h704;
      ex_wr_req_i = 1'b1; ex_addr_i = 32'h404; ex_wr_sel_i = 4'hC;
      #1;
      chk("r_post_ex_gnt", 32'(ex_gnt_o), 32'h1);
      chk("r_post_if_gnt", 32'(if_gnt_o), 32'h0);
      chk("r_post_ex_rvalid", 32'(ex_rvalid_o), 32'h0);
      chk("r_post_if_rvalid", 32'(if_rvalid_o), 32'h0);
      tick(); idle();
      #1;
      chk("r_post2_rvalid", {30'h0, if_rvalid_o, ex_rvalid_o}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
